// File: rtl/pe_dmux_rr_pkg.sv
// Shared types and helpers for the registered PE result demultiplexer.
// The broadcast option (PE_DMUX_BCAST_EN) is handled in pe_dmux_rr.
package pe_dmux_pkg;

   typedef enum logic {
      DMUX_EXPLICIT = 1'b0,
      DMUX_RR       = 1'b1
   } pe_dmux_mode_e;

   // A programmed burst length of zero behaves as a single beat per channel.
   function automatic logic [31:0] eff_burst(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/pe_dmux_rr_slot.sv
// One-entry valid/ready output register for a single demux channel.
// Accepts a new beat when empty or when the current beat drains this cycle.
module pe_dmux_slot #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         can_accept,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         vld_p1;
   logic [W-1:0] data_p1;

   assign can_accept = !vld_p1 || out_ready;
   assign out_valid  = vld_p1;
   assign out_data   = data_p1;

   // Stage boundary: input beat -> channel output register
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         data_p1 <= load_data;
      end else if (vld_p1 && out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

endmodule

// File: rtl/pe_dmux_rr.sv
// 1-to-N registered demux with explicit or round-robin routing.
// Optional broadcast in explicit mode when PE_DMUX_BCAST_EN is defined.
module pe_dmux_rr
   import pe_dmux_pkg::*;
#(
   parameter int W   = 24,
   parameter int N   = 4,
   parameter int BLW = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [BLW-1:0] burst_len,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [SW-1:0]  in_sel,
   input  logic [W-1:0]   in_data,
`ifdef PE_DMUX_BCAST_EN
   input  logic           in_bcast,
`endif
   output logic [N-1:0]   out_valid,
   input  logic [N-1:0]   out_ready,
   output logic [N*W-1:0] out_data,
   output logic           sel_err
);

   localparam logic [SW:0] N_L = (SW + 1)'(N);

   pe_dmux_mode_e  mode_cur;
   pe_dmux_mode_e  mode_p1;
   logic [SW-1:0]  rr_ptr;
   logic [BLW-1:0] beat_cnt;

   logic           mode_chg;
   logic [SW-1:0]  ptr_cur;
   logic [BLW-1:0] cnt_cur;
   logic [SW-1:0]  target;
   logic           bcast_act;
   logic           sel_oor;
   logic [N-1:0]   can_acc;
   logic           sel_acc;
   logic           accept;
   logic [N-1:0]   load;
   logic [SW-1:0]  ptr_nxt;
   logic [BLW-1:0] cnt_nxt;

   assign mode_cur = pe_dmux_mode_e'(mode);

   // A mode change restarts round-robin from channel 0 for this very beat.
   assign mode_chg = (mode_cur != mode_p1);
   assign ptr_cur  = mode_chg ? '0 : rr_ptr;
   assign cnt_cur  = mode_chg ? '0 : beat_cnt;
   assign target   = (mode_cur == DMUX_RR) ? ptr_cur : in_sel;

`ifdef PE_DMUX_BCAST_EN
   assign bcast_act = (mode_cur == DMUX_EXPLICIT) && in_bcast;
`else
   assign bcast_act = 1'b0;
`endif

   assign sel_oor = (mode_cur == DMUX_EXPLICIT) && !bcast_act && ({1'b0, in_sel} >= N_L);

   always_comb begin
      sel_acc = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (target == SW'(k)) sel_acc = can_acc[k];
      end
   end

   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (bcast_act)    in_ready = &can_acc;
         else if (sel_oor) in_ready = 1'b1;
         else              in_ready = sel_acc;
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < N; k++) begin
         load[k] = accept && !sel_oor && (bcast_act || (target == SW'(k)));
      end
   end

   // burst_len is re-sampled every beat; >= lets a lowered length advance at once.
   always_comb begin
      ptr_nxt = ptr_cur;
      cnt_nxt = cnt_cur;
      if ((mode_cur == DMUX_RR) && accept) begin
         if (32'(cnt_cur) >= (eff_burst(32'(burst_len)) - 32'd1)) begin
            cnt_nxt = '0;
            ptr_nxt = (ptr_cur == SW'(N - 1)) ? '0 : ptr_cur + SW'(1);
         end else begin
            cnt_nxt = cnt_cur + BLW'(1);
         end
      end
   end

   // Stage boundary: routing control state
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_p1  <= DMUX_EXPLICIT;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         sel_err  <= 1'b0;
      end else begin
         mode_p1  <= mode_cur;
         rr_ptr   <= ptr_nxt;
         beat_cnt <= cnt_nxt;
         if (accept && sel_oor) sel_err <= 1'b1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      pe_dmux_slot #(.W(W)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load       (load[k]),
         .load_data  (in_data),
         .out_ready  (out_ready[k]),
         .can_accept (can_acc[k]),
         .out_valid  (out_valid[k]),
         .out_data   (out_data[k*W +: W])
      );
   end

endmodule

// File: tb/tb_pe_dmux_rr.sv
// Directed bench for pe_dmux_rr: N=4 instance plus an N=3 instance for select range errors.
module tb_pe_dmux_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [7:0]  burst_len;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [23:0] in_data;
   logic        in_bcast;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [95:0] out_data;
   logic        sel_err;

   logic        v3;
   logic        rdy3;
   logic [1:0]  sel3;
   logic [2:0]  ov3;
   logic [71:0] od3;
   logic        err3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pe_dmux_rr #(.W(24), .N(4), .BLW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .burst_len (burst_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
`ifdef PE_DMUX_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_err   (sel_err)
   );

   pe_dmux_rr #(.W(24), .N(3), .BLW(8)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .burst_len (burst_len),
      .in_valid  (v3),
      .in_ready  (rdy3),
      .in_sel    (sel3),
      .in_data   (in_data),
`ifdef PE_DMUX_BCAST_EN
      .in_bcast  (1'b0),
`endif
      .out_valid (ov3),
      .out_ready (out_ready[2:0]),
      .out_data  (od3),
      .sel_err   (err3)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] ch(input int k);
      return out_data[k*24 +: 24];
   endfunction

   int rr2_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
   int rr0_ch [5]  = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1; mode = 1'b0; burst_len = 8'd0; in_valid = 1'b1; in_sel = 2'd0;
      in_data = 24'h5A5A5A; in_bcast = 1'b0; out_ready = 4'hF;
      v3 = 1'b0; sel3 = 2'd0;

      // reset with valid held high
      step();
      step();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_data", out_data, 96'd0);
      chk("rst_sel_err", sel_err, 1'b0);
      chk("rst_sel_err3", err3, 1'b0);
      rst = 1'b0; in_valid = 1'b0;
      step();
      chk("idle_out_valid", out_valid, 4'b0000);

      // explicit routing
      in_valid = 1'b1; in_sel = 2'd2; in_data = 24'h123456;
      #1 chk("exp_in_ready", in_ready, 1'b1);
      step();
      chk("exp_ov_ch2", out_valid, 4'b0100);
      chk("exp_data_ch2", ch(2), 24'h123456);
      in_sel = 2'd0; in_data = 24'hABCDEF;
      step();
      chk("exp_ov_ch0", out_valid, 4'b0001);
      chk("exp_data_ch0", ch(0), 24'hABCDEF);
      in_valid = 1'b0;
      step();
      chk("exp_drained", out_valid, 4'b0000);

      // backpressure on channel 1
      out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 24'h111111;
      #1 chk("bp_first_ready", in_ready, 1'b1);
      step();
      in_data = 24'h222222;
      #1 chk("bp_second_stall", in_ready, 1'b0);
      step();
      chk("bp_hold_valid", out_valid, 4'b0010);
      chk("bp_hold_data", ch(1), 24'h111111);
      out_ready = 4'hF;
      #1 chk("bp_release_ready", in_ready, 1'b1);
      step();
      chk("bp_second_valid", out_valid, 4'b0010);
      chk("bp_second_data", ch(1), 24'h222222);
      in_valid = 1'b0;
      step();

      // round-robin, burst of 2
      mode = 1'b1; burst_len = 8'd2; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 24'(i + 1);
         #1 chk("rr2_ready", in_ready, 1'b1);
         step();
         chk($sformatf("rr2_ov_%0d", i + 1), out_valid, 4'b0001 << rr2_ch[i]);
         chk($sformatf("rr2_data_%0d", i + 1), ch(rr2_ch[i]), 24'(i + 1));
      end
      in_valid = 1'b0; mode = 1'b0;
      step();

      // round-robin, burst_len 0 behaves as 1
      mode = 1'b1; burst_len = 8'd0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 24'h100 + 24'(i);
         step();
         chk($sformatf("rr0_ov_%0d", i), out_valid, 4'b0001 << rr0_ch[i]);
         chk($sformatf("rr0_data_%0d", i), ch(rr0_ch[i]), 24'h100 + 24'(i));
      end
      in_valid = 1'b0; mode = 1'b0;
      step();
      step();

      // out-of-range select on the N=3 instance
      v3 = 1'b1; sel3 = 2'd3; in_data = 24'hDEAD00;
      #1 chk("oor_ready", rdy3, 1'b1);
      step();
      v3 = 1'b0;
      chk("oor_ov", ov3, 3'b000);
      chk("oor_err", err3, 1'b1);
      step();
      step();
      chk("oor_err_sticky", err3, 1'b1);
      chk("oor_ov_stay", ov3, 3'b000);
      chk("n4_sel_err", sel_err, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("oor_err_cleared", err3, 1'b0);

`ifdef PE_DMUX_BCAST_EN
      // broadcast blocked by a full channel 3
      out_ready = 4'b0111; in_valid = 1'b1; in_sel = 2'd3; in_data = 24'h333333;
      step();
      in_bcast = 1'b1; in_data = 24'h00FF00;
      #1 chk("bc_blocked", in_ready, 1'b0);
      step();
      chk("bc_hold_ch3", ch(3), 24'h333333);
      out_ready = 4'hF;
      #1 chk("bc_release_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0; in_bcast = 1'b0;
      chk("bc_ov", out_valid, 4'hF);
      chk("bc_data", out_data, {4{24'h00FF00}});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
